uart_regbus_responder: RTL and testbench
========================================

Name: uart_regbus_responder

Overview:
- Byte-level responder on the far side of the UART byte interface.
- Decodes a minimal register-access command stream arriving on bytercvd/q.
- Drives a simple parallel register bus, and returns read data (and optionally write acks) through the UART transmit byte interface (load/d/txbusy).
- Sits between the UART core and local control/status registers; lets a host PC poke registers over serial.

Parameters:
ADDR_W, 4, register bus address width; low ADDR_W bits of the address byte are used, upper bits ignored
TIMEOUT, 1000, clk cycles allowed between bytes of one command before abort; legal range 2..65535
TO_W, 16, width of the inter-byte timeout counter; must hold TIMEOUT

Ports:
clk  in  1  system clock, shared with the UART core
rst_n  in  1  asynchronous active-low reset
bytercvd  in  1  one-cycle strobe from the UART receiver: q holds a new byte
q  in  8  received byte
txbusy  in  1  UART transmitter busy; load must not be asserted while high
load  out  1  one-cycle strobe: d is loaded into the UART transmitter
d  out  8  byte to transmit, valid while load is high
bus_wr  out  1  one-cycle register write strobe
bus_rd  out  1  one-cycle register read strobe
bus_addr  out  ADDR_W  register address, held stable from the strobe until the next command
bus_wdata  out  8  write data, valid with bus_wr
bus_rdata  in  8  read data, sampled exactly one cycle after bus_rd
drop  out  1  one-cycle pulse: a received byte was discarded

Behaviour:
- Reset (async assert, sync release): state IDLE; load, bus_wr, bus_rd, drop = 0; d, bus_addr, bus_wdata = 0; timeout counter = 0.
- Command protocol:
  - 0x57 ('W'), addr, data -> register write.
  - 0x52 ('R'), addr -> register read; the read byte is transmitted.
  - Any other byte in IDLE is ignored silently; drop is not asserted.
- States: IDLE, GET_ADDR, GET_DATA, RD_STB, RD_CAP, TX_WAIT.
  - IDLE: on bytercvd with q==0x52 or q==0x57, go to GET_ADDR and latch the command type.
  - GET_ADDR, on bytercvd: bus_addr <= q[ADDR_W-1:0].
    - Write command: go to GET_DATA.
    - Read command: go to RD_STB.
  - GET_DATA, on bytercvd: bus_wdata <= q and bus_wr=1 on the next cycle (registered). Then go to IDLE, or to TX_WAIT with d=0x2B if UART_WRITE_ACK_EN is defined.
  - RD_STB: bus_rd=1 for exactly this cycle; go to RD_CAP.
  - RD_CAP: d <= bus_rdata; go to TX_WAIT.
  - TX_WAIT: the first cycle txbusy==0, load=1 for one cycle; go to IDLE.
- Latency, address byte strobe at cycle m:
  - bus_rd high in m+1.
  - rdata captured at the end of m+2.
  - load earliest in m+3 if txbusy is low.
  - bus_wr high in the cycle after the data-byte strobe.
- Timeout:
  - The counter is cleared on every accepted byte and counts only in GET_ADDR/GET_DATA.
  - On reaching TIMEOUT, return to IDLE with no bus strobe and no transmit.
  - bytercvd in the same cycle as expiry: the byte wins and is accepted.
- Overrun: bytercvd while in RD_STB, RD_CAP or TX_WAIT -> byte discarded, drop=1 next cycle, state unaffected.
- load is never asserted in two consecutive cycles.
  - At least one idle cycle always separates loads, because txbusy rises one cycle after load.
  - Only one byte is transmitted per command.
- bus_wr and bus_rd are never high together.
- Reset mid-command aborts without strobes. The UART core itself has no reset; a byte already loaded finishes transmitting.

Optional Feature:
- Macro UART_WRITE_ACK_EN.
- Defined: every completed write transmits 0x2B ('+') via TX_WAIT after bus_wr.
- Undefined: writes are silent and GET_DATA returns directly to IDLE; TX_WAIT is reached only from reads.

Test Plan:
- Write, txbusy=0: bytes 0x57,0x03,0xA5 -> bus_wr=1 one cycle after 3rd strobe, bus_addr=3, bus_wdata=0xA5; load never asserted (load=1 with d=0x2B when UART_WRITE_ACK_EN defined).
- Read: bytes 0x52,0x05, bus_rdata=0x3C -> bus_rd at m+1 with bus_addr=5; load=1, d=0x3C at m+3.
- Read with txbusy held high 50 cycles after RD_CAP -> load delayed to the first cycle txbusy=0, asserted exactly once.
- Timeout, TIMEOUT=20: 0x57,0x01, then silence 30 cycles, then 0x52,0x02 -> no bus_wr; read of addr 2 completes normally.
- Overrun: 0x52,0x00 with txbusy high, 0x11 received during TX_WAIT -> drop pulses once; 0x11 not decoded; read byte transmitted after txbusy falls.
- Async reset asserted in GET_DATA -> all outputs 0 immediately; after release, 0x41 ignored, then a full write command works.

Source files
------------

// File: rtl/uart_regbus_responder.sv
// Serial register-access responder: decodes 'W' addr data / 'R' addr commands from the UART
// receiver, drives a parallel register bus and returns read data. Define UART_WRITE_ACK_EN to ack writes.
module uart_regbus_responder #(
   parameter int unsigned ADDR_W  = 4,
   parameter int unsigned TIMEOUT = 1000,
   parameter int unsigned TO_W    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bytercvd,
   input  logic [7:0]        q,
   input  logic              txbusy,
   output logic              load,
   output logic [7:0]        d,
   output logic              bus_wr,
   output logic              bus_rd,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [7:0]        bus_wdata,
   input  logic [7:0]        bus_rdata,
   output logic              drop
);

   typedef enum logic [2:0] {
      StIdle, StGetAddr, StGetData, StRdStb, StRdCap, StTxWait
   } state_e;

   localparam logic [7:0]      CmdWrite = 8'h57;
   localparam logic [7:0]      CmdRead  = 8'h52;
   localparam logic [7:0]      AckByte  = 8'h2B;
   localparam logic [TO_W-1:0] ToLast   = TO_W'(TIMEOUT - 1);

   state_e              state_q, state_d;
   logic                is_wr_q, is_wr_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic                bus_wr_q, bus_wr_d;
   logic                bus_rd_q, bus_rd_d;
   logic                drop_q, drop_d;
   logic [7:0]          d_q, d_d;
   logic [7:0]          wdata_q, wdata_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;

   always_comb begin
      state_d  = state_q;
      is_wr_d  = is_wr_q;
      to_cnt_d = to_cnt_q;
      bus_wr_d = 1'b0;
      bus_rd_d = 1'b0;
      drop_d   = 1'b0;
      d_d      = d_q;
      wdata_d  = wdata_q;
      addr_d   = addr_q;
      unique case (state_q)
         StIdle: begin
            to_cnt_d = '0;
            if (bytercvd && (q == CmdWrite || q == CmdRead)) begin
               state_d = StGetAddr;
               is_wr_d = (q == CmdWrite);
            end
         end
         StGetAddr: begin
            if (bytercvd) begin
               addr_d   = q[ADDR_W-1:0];
               to_cnt_d = '0;
               if (is_wr_q) begin
                  state_d = StGetData;
               end else begin
                  state_d  = StRdStb;
                  bus_rd_d = 1'b1;
               end
            end else if (to_cnt_q == ToLast) begin
               state_d  = StIdle;
               to_cnt_d = '0;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         StGetData: begin
            // A byte arriving in the expiry cycle still completes the command.
            if (bytercvd) begin
               wdata_d  = q;
               bus_wr_d = 1'b1;
               to_cnt_d = '0;
`ifdef UART_WRITE_ACK_EN
               state_d  = StTxWait;
               d_d      = AckByte;
`else
               state_d  = StIdle;
`endif
            end else if (to_cnt_q == ToLast) begin
               state_d  = StIdle;
               to_cnt_d = '0;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         StRdStb: begin
            state_d = StRdCap;
            drop_d  = bytercvd;
         end
         StRdCap: begin
            d_d     = bus_rdata;
            state_d = StTxWait;
            drop_d  = bytercvd;
         end
         StTxWait: begin
            drop_d = bytercvd;
            if (!txbusy) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         is_wr_q  <= 1'b0;
         to_cnt_q <= '0;
         bus_wr_q <= 1'b0;
         bus_rd_q <= 1'b0;
         drop_q   <= 1'b0;
         d_q      <= '0;
         wdata_q  <= '0;
         addr_q   <= '0;
      end else begin
         state_q  <= state_d;
         is_wr_q  <= is_wr_d;
         to_cnt_q <= to_cnt_d;
         bus_wr_q <= bus_wr_d;
         bus_rd_q <= bus_rd_d;
         drop_q   <= drop_d;
         d_q      <= d_d;
         wdata_q  <= wdata_d;
         addr_q   <= addr_d;
      end
   end

   // load follows txbusy in the same cycle so the transmitter is never loaded while busy.
   assign load      = (state_q == StTxWait) && !txbusy;
   assign d         = d_q;
   assign bus_wr    = bus_wr_q;
   assign bus_rd    = bus_rd_q;
   assign bus_addr  = addr_q;
   assign bus_wdata = wdata_q;
   assign drop      = drop_q;

endmodule

// File: tb/tb_uart_regbus_responder.sv
// Directed self-checking bench for uart_regbus_responder (TIMEOUT=20).
module tb_uart_regbus_responder;

   localparam int unsigned AddrW = 4;
`ifdef UART_WRITE_ACK_EN
   localparam int ExpAck = 1;
`else
   localparam int ExpAck = 0;
`endif

   logic             clk = 1'b0;
   logic             rst_n;
   logic             bytercvd;
   logic [7:0]       q;
   logic             txbusy;
   logic             load;
   logic [7:0]       d;
   logic             bus_wr;
   logic             bus_rd;
   logic [AddrW-1:0] bus_addr;
   logic [7:0]       bus_wdata;
   logic [7:0]       bus_rdata;
   logic             drop;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   int last_rx_cyc, wr_cnt, wr_cyc, rd_cnt, rd_cyc, ld_cnt, ld_cyc, drop_cnt;
   int both_cnt = 0;
   int consec_cnt = 0;
   logic [7:0] wr_addr, wr_data, rd_addr, ld_data;
   logic prev_load = 1'b0;

   uart_regbus_responder #(
      .ADDR_W  (AddrW),
      .TIMEOUT (20),
      .TO_W    (16)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bytercvd  (bytercvd),
      .q         (q),
      .txbusy    (txbusy),
      .load      (load),
      .d         (d),
      .bus_wr    (bus_wr),
      .bus_rd    (bus_rd),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_rdata (bus_rdata),
      .drop      (drop)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Event log, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bytercvd) last_rx_cyc = cyc;
         if (bus_wr) begin
            wr_cnt++; wr_cyc = cyc; wr_addr = 8'(bus_addr); wr_data = bus_wdata;
         end
         if (bus_rd) begin
            rd_cnt++; rd_cyc = cyc; rd_addr = 8'(bus_addr);
         end
         if (load) begin
            ld_cnt++; ld_cyc = cyc; ld_data = d;
            if (prev_load) consec_cnt++;
         end
         if (drop) drop_cnt++;
         if (bus_wr && bus_rd) both_cnt++;
         prev_load = load;
      end else begin
         prev_load = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Strobes one byte in the current cycle; returns one cycle later with bytercvd low.
   task automatic send_byte(input logic [7:0] b);
      bytercvd = 1'b1;
      q        = b;
      wait_cycles(1);
      bytercvd = 1'b0;
   endtask

   task automatic clear_log();
      wr_cnt = 0; rd_cnt = 0; ld_cnt = 0; drop_cnt = 0;
      wr_cyc = -1; rd_cyc = -1; ld_cyc = -1; last_rx_cyc = -1;
      wr_addr = 8'hFF; wr_data = 8'h00; rd_addr = 8'hFF; ld_data = 8'h00;
   endtask

   task automatic check_outputs_zero(input string pfx);
      check({pfx, "_load"}, 32'(load), 0);
      check({pfx, "_bus_wr"}, 32'(bus_wr), 0);
      check({pfx, "_bus_rd"}, 32'(bus_rd), 0);
      check({pfx, "_drop"}, 32'(drop), 0);
      check({pfx, "_d"}, 32'(d), 0);
      check({pfx, "_bus_addr"}, 32'(bus_addr), 0);
      check({pfx, "_bus_wdata"}, 32'(bus_wdata), 0);
   endtask

   int m, t;

   initial begin
      rst_n = 1'b0; bytercvd = 1'b0; q = 8'h00; txbusy = 1'b0; bus_rdata = 8'h00;
      clear_log();
      #12;
      check_outputs_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;
      wait_cycles(2);

      // Write
      clear_log();
      send_byte(8'h57); send_byte(8'h03); send_byte(8'hA5);
      m = last_rx_cyc;
      wait_cycles(6);
      check("wr_count", 32'(wr_cnt), 1);
      check("wr_latency", 32'(wr_cyc), 32'(m + 1));
      check("wr_addr", 32'(wr_addr), 3);
      check("wr_data", 32'(wr_data), 32'hA5);
      check("wr_load_count", 32'(ld_cnt), 32'(ExpAck));
      check("wr_no_rd", 32'(rd_cnt), 0);

      // Read, transmitter idle
      clear_log();
      bus_rdata = 8'h3C;
      send_byte(8'h52); send_byte(8'h05);
      m = last_rx_cyc;
      wait_cycles(8);
      check("rd_count", 32'(rd_cnt), 1);
      check("rd_latency", 32'(rd_cyc), 32'(m + 1));
      check("rd_addr", 32'(rd_addr), 5);
      check("rd_load_count", 32'(ld_cnt), 1);
      check("rd_load_latency", 32'(ld_cyc), 32'(m + 3));
      check("rd_load_data", 32'(ld_data), 32'h3C);

      // Read, transmitter busy
      clear_log();
      txbusy = 1'b1;
      bus_rdata = 8'h99;
      send_byte(8'h52); send_byte(8'h07);
      wait_cycles(52);
      check("busy_no_load", 32'(ld_cnt), 0);
      txbusy = 1'b0;
      t = cyc;
      wait_cycles(10);
      check("busy_load_count", 32'(ld_cnt), 1);
      check("busy_load_cycle", 32'(ld_cyc), 32'(t));
      check("busy_load_data", 32'(ld_data), 32'h99);

      // Timeout abandons a write, then a read completes
      clear_log();
      bus_rdata = 8'h5A;
      send_byte(8'h57); send_byte(8'h01);
      wait_cycles(30);
      send_byte(8'h52); send_byte(8'h02);
      wait_cycles(8);
      check("to_no_wr", 32'(wr_cnt), 0);
      check("to_rd_count", 32'(rd_cnt), 1);
      check("to_rd_addr", 32'(rd_addr), 2);
      check("to_load_count", 32'(ld_cnt), 1);
      check("to_load_data", 32'(ld_data), 32'h5A);

      // Data byte in the expiry cycle is accepted
      clear_log();
      send_byte(8'h57); send_byte(8'h0A);
      wait_cycles(19);
      send_byte(8'h6D);
      wait_cycles(4);
      check("to_edge_wr_count", 32'(wr_cnt), 1);
      check("to_edge_wr_data", 32'(wr_data), 32'h6D);
      wait_cycles(4);

      // One cycle later the command has already been abandoned
      clear_log();
      send_byte(8'h57); send_byte(8'h0B);
      wait_cycles(20);
      send_byte(8'hAA);
      wait_cycles(4);
      check("to_late_no_wr", 32'(wr_cnt), 0);

      // Overrun during TX_WAIT
      clear_log();
      txbusy = 1'b1;
      bus_rdata = 8'h66;
      send_byte(8'h52); send_byte(8'h00);
      wait_cycles(3);
      send_byte(8'h11);
      wait_cycles(5);
      check("ovr_drop_count", 32'(drop_cnt), 1);
      check("ovr_no_load_yet", 32'(ld_cnt), 0);
      txbusy = 1'b0;
      wait_cycles(5);
      check("ovr_load_count", 32'(ld_cnt), 1);
      check("ovr_load_data", 32'(ld_data), 32'h66);
      check("ovr_rd_count", 32'(rd_cnt), 1);
      check("ovr_no_wr", 32'(wr_cnt), 0);

      // Async reset in GET_DATA
      clear_log();
      send_byte(8'h57); send_byte(8'h04);
      #2 rst_n = 1'b0;
      #1;
      check_outputs_zero("async_rst");
      wait_cycles(3);
      rst_n = 1'b1;
      wait_cycles(2);
      clear_log();
      send_byte(8'h41);
      wait_cycles(2);
      send_byte(8'h57); send_byte(8'h09); send_byte(8'hC3);
      wait_cycles(6);
      check("post_rst_wr_count", 32'(wr_cnt), 1);
      check("post_rst_wr_addr", 32'(wr_addr), 9);
      check("post_rst_wr_data", 32'(wr_data), 32'hC3);
      check("post_rst_no_rd", 32'(rd_cnt), 0);
      check("post_rst_no_drop", 32'(drop_cnt), 0);

      check("wr_rd_overlap", 32'(both_cnt), 0);
      check("load_back_to_back", 32'(consec_cnt), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
